hazard_ctl: RTL and testbench

Decode-side hazard and pipeline-control unit for the 5-stage 16-bit pipeline. It mirrors the destination registers held in the ID/EX and EX/MEM pipeline registers in a two-entry scoreboard. From that state it drives the controls for the ID/EX register: stall the front end on read-after-write hazards, inject bubbles, squash IF/ID on a taken branch or jump resolved in EX, and drain the pipeline on `halt`. The pipeline has no forwarding. The register file provides write-before-read bypass, so only producers in EX and MEM cause hazards.

---
 rtl/hazard_ctl.sv | 104 ++++++++++
 tb/tb_hazard_ctl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctl.sv
// Decode-side RAW hazard, redirect squash and halt-drain control for the 5-stage pipeline.
// stall/bubble/flushIFID are combinational in the same cycle; haltOut is a flop; stall holds PC and IF/ID.
module hazard_ctl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        decValid,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic        useRs,
    input  logic        useRt,
    input  logic [2:0]  decWritereg,
    input  logic        decRegWrite,
    input  logic        decHalt,
    input  logic        redirect,
    output logic        stall,
    output logic        bubble,
    output logic        flushIFID,
    output logic        haltOut,
    output logic [15:0] stallCount
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [1:0] drain_cnt;
    logic       ex_v;
    logic [2:0] ex_reg;
    logic       mem_v;
    logic [2:0] mem_reg;

    logic       rs_hit;
    logic       rt_hit;
    logic       hazard;
    logic       run_stall;

    // No forwarding: any in-flight writer in EX or MEM blocks a matching reader.
    always_comb begin
        rs_hit    = useRs & ((ex_v & (ex_reg == rs)) | (mem_v & (mem_reg == rs)));
        rt_hit    = useRt & ((ex_v & (ex_reg == rt)) | (mem_v & (mem_reg == rt)));
        hazard    = decValid & (rs_hit | rt_hit);
        run_stall = hazard & ~redirect;
    end

    always_comb begin
        stall     = 1'b1;
        bubble    = 1'b1;
        flushIFID = 1'b0;
        if (state == RUN) begin
            stall     = run_stall;
            bubble    = run_stall | redirect;
            flushIFID = redirect;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            drain_cnt  <= 2'd0;
            ex_v       <= 1'b0;
            ex_reg     <= 3'd0;
            mem_v      <= 1'b0;
            mem_reg    <= 3'd0;
            stallCount <= 16'd0;
            haltOut    <= 1'b0;
        end else begin
            mem_v   <= ex_v;
            mem_reg <= ex_reg;
            ex_v    <= decValid & decRegWrite & ~bubble & (state == RUN);
            ex_reg  <= decWritereg;

            if ((state == RUN) && stall && (stallCount != 16'hFFFF)) begin
                stallCount <= stallCount + 16'd1;
            end

            case (state)
                RUN: begin
                    // HALT itself issues into ID/EX; the drain covers EX, MEM and WB.
                    if (decValid && decHalt && !stall && !redirect) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state   <= HALTED;
                        haltOut <= 1'b1;
                    end
                end
                HALTED: begin
                    haltOut <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: stall timing, redirect squash, halt drain, saturation and reset.
module tb_hazard_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        decValid;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        useRs;
    logic        useRt;
    logic [2:0]  decWritereg;
    logic        decRegWrite;
    logic        decHalt;
    logic        redirect;
    logic        stall;
    logic        bubble;
    logic        flushIFID;
    logic        haltOut;
    logic [15:0] stallCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .decValid(decValid), .rs(rs), .rt(rt),
        .useRs(useRs), .useRt(useRt), .decWritereg(decWritereg),
        .decRegWrite(decRegWrite), .decHalt(decHalt), .redirect(redirect),
        .stall(stall), .bubble(bubble), .flushIFID(flushIFID),
        .haltOut(haltOut), .stallCount(stallCount)
    );

    task automatic drive(input logic v, input logic [2:0] wreg, input logic wr,
                         input logic [2:0] s, input logic us, input logic [2:0] t,
                         input logic ut, input logic h, input logic rd);
        decValid = v; decWritereg = wreg; decRegWrite = wr;
        rs = s; useRs = us; rt = t; useRt = ut; decHalt = h; redirect = rd;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        next();
        next();
        rst = 1'b0;
        sample();
        checks++;
        if ({stall, bubble, flushIFID, haltOut} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: stall/bubble/flush/halt=%b expected 0000", {stall, bubble, flushIFID, haltOut});
        end
        checks++;
        if (stallCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: stallCount=%0d expected 0", stallCount);
        end
        checks++;
        if ({dut.ex_v, dut.mem_v} !== 2'b00) begin
            errors++;
            $display("FAIL reset_scoreboard: exV/memV=%b expected 00", {dut.ex_v, dut.mem_v});
        end
        next();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        sample();
        checks++;
        if ({stall, bubble, flushIFID} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_producer: stall/bubble/flush=%b expected 000", {stall, bubble, flushIFID});
        end
        next();
        drive(1'b1, 3'd4, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        sample();
        checks++;
        if ({stall, bubble, flushIFID} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_stall1: stall/bubble/flush=%b expected 110", {stall, bubble, flushIFID});
        end
        next();
        sample();
        checks++;
        if ({stall, bubble, flushIFID} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_stall2: stall/bubble/flush=%b expected 110", {stall, bubble, flushIFID});
        end
        next();
        sample();
        checks++;
        if ({stall, bubble, flushIFID} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_issue: stall/bubble/flush=%b expected 000", {stall, bubble, flushIFID});
        end
        checks++;
        if (stallCount !== 16'd2) begin
            errors++;
            $display("FAIL b2b_count: stallCount=%0d expected 2", stallCount);
        end
        next();
        idle();
        next();
        next();
    endtask

    task automatic test_distance();
        // distance 2 via rt
        drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        next();
        drive(1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        next();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if ({stall, bubble} !== 2'b11) begin
            errors++;
            $display("FAIL dist2_stall: stall/bubble=%b expected 11", {stall, bubble});
        end
        next();
        sample();
        checks++;
        if ({stall, bubble} !== 2'b00 || stallCount !== 16'd3) begin
            errors++;
            $display("FAIL dist2_issue: stall/bubble=%b count=%0d expected 00 count 3", {stall, bubble}, stallCount);
        end
        next();
        idle();
        next();
        next();
        // distance 3: no stall
        drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        next();
        drive(1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        next();
        next();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        sample();
        checks++;
        if ({stall, bubble} !== 2'b00 || stallCount !== 16'd3) begin
            errors++;
            $display("FAIL dist3_nostall: stall/bubble=%b count=%0d expected 00 count 3", {stall, bubble}, stallCount);
        end
        next();
        // R0 is tracked; an invalid decode never stalls
        drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        next();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        sample();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL invalid_nostall: stall=%b expected 0", stall);
        end
        next();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        sample();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL r0_stall: stall=%b expected 1", stall);
        end
        next();
        sample();
        checks++;
        if (stall !== 1'b0 || stallCount !== 16'd4) begin
            errors++;
            $display("FAIL r0_release: stall=%b count=%0d expected 0 count 4", stall, stallCount);
        end
        next();
        idle();
        next();
        next();
    endtask

    task automatic test_redirect();
        drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        next();
        drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
        sample();
        checks++;
        if ({stall, bubble, flushIFID} !== 3'b011 || dut.ex_v !== 1'b1) begin
            errors++;
            $display("FAIL redirect_hazard: stall/bubble/flush=%b exV=%b expected 011 exV 1", {stall, bubble, flushIFID}, dut.ex_v);
        end
        next();
        idle();
        sample();
        checks++;
        if (dut.ex_v !== 1'b0 || {stall, bubble, flushIFID} !== 3'b000 || stallCount !== 16'd4) begin
            errors++;
            $display("FAIL redirect_squash: exV=%b sbf=%b count=%0d expected exV 0 sbf 000 count 4", dut.ex_v, {stall, bubble, flushIFID}, stallCount);
        end
        next();
        next();
    endtask

    task automatic test_halt();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        sample();
        checks++;
        if ({stall, bubble} !== 2'b00) begin
            errors++;
            $display("FAIL halt_issue: stall/bubble=%b expected 00", {stall, bubble});
        end
        next();
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
            else if (c == 5) drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
            else idle();
            sample();
            checks++;
            if ({stall, bubble, flushIFID} !== 3'b110 || haltOut !== (c >= 4)) begin
                errors++;
                $display("FAIL halt_drain_c%0d: sbf=%b haltOut=%b expected 110 haltOut %b", c, {stall, bubble, flushIFID}, haltOut, (c >= 4));
            end
            next();
        end
        sample();
        checks++;
        if (dut.ex_v !== 1'b0 || stallCount !== 16'd4) begin
            errors++;
            $display("FAIL halted_frozen: exV=%b count=%0d expected exV 0 count 4", dut.ex_v, stallCount);
        end
        next();
    endtask

    task automatic test_reset_halted();
        rst = 1'b1;
        idle();
        next();
        rst = 1'b0;
        sample();
        checks++;
        if (haltOut !== 1'b0 || stall !== 1'b0 || int'(dut.state) != 0 || stallCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_halted: haltOut=%b stall=%b state=%0d count=%0d expected 0 0 0 0", haltOut, stall, int'(dut.state), stallCount);
        end
        next();
    endtask

    task automatic test_saturation();
        // Self-dependent writer: issue, stall, stall repeating -> 2 stalls per 3 cycles.
        drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 98310; n++) begin
            sample();
            if (n == 300) begin
                checks++;
                if (stall !== 1'b0 || stallCount !== 16'd200) begin
                    errors++;
                    $display("FAIL sat_midpoint: stall=%b count=%0d expected 0 count 200", stall, stallCount);
                end
            end
            if (n == 301) begin
                checks++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_pattern: stall=%b expected 1", stall);
                end
            end
            if (n == 98301) begin
                checks++;
                if (stallCount !== 16'hFFFE) begin
                    errors++;
                    $display("FAIL sat_before: count=%h expected fffe", stallCount);
                end
            end
            next();
        end
        sample();
        checks++;
        if (stallCount !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: count=%h expected ffff", stallCount);
        end
        next();
        idle();
        next();
        next();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        next();
        drive(1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        sample();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall_pre: stall=%b expected 1", stall);
        end
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        sample();
        checks++;
        if (stall !== 1'b0 || {dut.ex_v, dut.mem_v} !== 2'b00 || stallCount !== 16'd0) begin
            errors++;
            $display("FAIL mid_stall_reset: stall=%b exV/memV=%b count=%0d expected 0 00 0", stall, {dut.ex_v, dut.mem_v}, stallCount);
        end
        next();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_back_to_back();
        test_distance();
        test_redirect();
        test_halt();
        test_reset_halted();
        test_saturation();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
